// File: rtl/upd_xhd_ctrl.sv
// Sequencer for the dW/dU update stage: drives the read address generator,
// aligns MAC accumulate/clear strobes to read-data return, and issues dW writes.
module upd_xhd_ctrl #(
  parameter int ADDR_WIDTH = 12,
  parameter int TIMESTEP   = 7,
  parameter int NUM_CELL   = 53,
  parameter int NUM_INPUT  = 53,
  parameter int DELAY      = 1,
  parameter int LAT        = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_abort,
  output logic                  o_gen_clr,
  output logic                  o_gen_en,
  output logic                  o_acc_clr,
  output logic                  o_acc_en,
  output logic                  o_wr_en,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int PERIOD = TIMESTEP + DELAY;
  localparam int PAIRS  = NUM_CELL * NUM_INPUT;

  // RUN length is never counted directly; only the loop bounds must fit.
  if (PAIRS > 2**ADDR_WIDTH || PERIOD > 2**ADDR_WIDTH || LAT < 1) begin : g_bad_cfg
    $error("upd_xhd_ctrl: configuration does not fit ADDR_WIDTH or LAT < 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [ADDR_WIDTH-1:0] k, j, c, p, dcnt;
  logic [LAT-1:0]        ipipe, fpipe;
  logic [LAT:0]          lpipe;
  logic [ADDR_WIDTH-1:0] apipe [LAT];

  logic issue, first, last, k_wrap, j_wrap, run_end, drain_end;

  always_comb begin
    issue     = (state == S_RUN) && (k < ADDR_WIDTH'(TIMESTEP));
    first     = issue && (k == '0);
    last      = issue && (k == ADDR_WIDTH'(TIMESTEP - 1));
    k_wrap    = (k == ADDR_WIDTH'(PERIOD - 1));
    j_wrap    = (j == ADDR_WIDTH'(NUM_INPUT - 1));
    run_end   = k_wrap && j_wrap && (c == ADDR_WIDTH'(NUM_CELL - 1));
    drain_end = (dcnt == ADDR_WIDTH'(LAT));
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (i_start) state_nx = S_CLR;
      S_CLR:   state_nx = S_RUN;
      S_RUN:   if (run_end) state_nx = S_DRAIN;
      S_DRAIN: if (drain_end) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (i_abort) state_nx = S_IDLE;
  end

  assign o_acc_en  = ipipe[LAT-1];
  assign o_acc_clr = fpipe[LAT-1];
  assign o_wr_en   = lpipe[LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      o_gen_clr <= 1'b0;
      o_gen_en  <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_wr_addr <= '0;
      k         <= '0;
      j         <= '0;
      c         <= '0;
      p         <= '0;
      dcnt      <= '0;
      ipipe     <= '0;
      fpipe     <= '0;
      lpipe     <= '0;
      for (int i = 0; i < LAT; i++) apipe[i] <= '0;
    end else begin
      state     <= state_nx;
      o_gen_clr <= (state_nx == S_CLR);
      o_gen_en  <= (state_nx == S_RUN);
      o_busy    <= (state_nx == S_CLR) || (state_nx == S_RUN) ||
                   (state_nx == S_DRAIN);
      o_done    <= (state_nx == S_DONE);
      if (i_abort) begin
        o_wr_addr <= '0;
        k         <= '0;
        j         <= '0;
        c         <= '0;
        p         <= '0;
        dcnt      <= '0;
        ipipe     <= '0;
        fpipe     <= '0;
        lpipe     <= '0;
        for (int i = 0; i < LAT; i++) apipe[i] <= '0;
      end else begin
        ipipe[0] <= issue;
        fpipe[0] <= first;
        lpipe[0] <= last;
        apipe[0] <= p;
        for (int i = 1; i < LAT; i++) begin
          ipipe[i] <= ipipe[i-1];
          fpipe[i] <= fpipe[i-1];
          apipe[i] <= apipe[i-1];
        end
        for (int i = 1; i <= LAT; i++) lpipe[i] <= lpipe[i-1];
        // Address register tracks the write strobe and holds between writes.
        if (state_nx == S_CLR) o_wr_addr <= '0;
        else if (lpipe[LAT-1]) o_wr_addr <= apipe[LAT-1];
        dcnt <= (state == S_DRAIN) ? dcnt + 1'b1 : '0;
        if (state == S_CLR) begin
          k <= '0;
          j <= '0;
          c <= '0;
          p <= '0;
        end else if (state == S_RUN) begin
          k <= k_wrap ? '0 : k + 1'b1;
          if (k_wrap) begin
            p <= p + 1'b1;
            j <= j_wrap ? '0 : j + 1'b1;
            if (j_wrap) c <= c + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_upd_xhd_ctrl.sv
// Bench for upd_xhd_ctrl: small config checked cycle by cycle against a
// closed-form timing model, default config checked for totals.
module tb_upd_xhd_ctrl;

  localparam int T = 3;
  localparam int NC = 2;
  localparam int NI = 2;
  localparam int D = 1;
  localparam int L = 2;
  localparam int P = T + D;
  localparam int R = NC * NI * P;
  localparam int TDONE = 3 + R + L;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic s_start = 1'b0, s_abort = 1'b0;
  logic s_gen_clr, s_gen_en, s_acc_clr, s_acc_en, s_wr_en, s_busy, s_done;
  logic [11:0] s_wr_addr;

  logic d_start = 1'b0, d_abort = 1'b0;
  logic d_gen_clr, d_gen_en, d_acc_clr, d_acc_en, d_wr_en, d_busy, d_done;
  logic [11:0] d_wr_addr;

  int checks = 0;
  int errors = 0;

  upd_xhd_ctrl #(
    .ADDR_WIDTH(12), .TIMESTEP(T), .NUM_CELL(NC),
    .NUM_INPUT(NI), .DELAY(D), .LAT(L)
  ) u_small (
    .clk(clk), .rst(rst), .i_start(s_start), .i_abort(s_abort),
    .o_gen_clr(s_gen_clr), .o_gen_en(s_gen_en), .o_acc_clr(s_acc_clr),
    .o_acc_en(s_acc_en), .o_wr_en(s_wr_en), .o_wr_addr(s_wr_addr),
    .o_busy(s_busy), .o_done(s_done)
  );

  upd_xhd_ctrl u_dflt (
    .clk(clk), .rst(rst), .i_start(d_start), .i_abort(d_abort),
    .o_gen_clr(d_gen_clr), .o_gen_en(d_gen_en), .o_acc_clr(d_acc_clr),
    .o_acc_en(d_acc_en), .o_wr_en(d_wr_en), .o_wr_addr(d_wr_addr),
    .o_busy(d_busy), .o_done(d_done)
  );

  typedef struct packed {
    logic [6:0]  flags;
    logic [11:0] addr;
    logic        addr_chk;
  } exp_t;

  // Expected outputs t cycles after the start cycle, from the run schedule.
  function automatic exp_t model(int t, int abort_at);
    exp_t e;
    int u, v;
    logic gclr, gen, aclr, aen, wen, busy, done;
    e = '0;
    if (abort_at >= 0 && t > abort_at) begin
      e.addr_chk = 1'b1;
      return e;
    end
    gclr = (t == 1);
    gen  = (t >= 2 && t < 2 + R);
    u    = t - 2 - L;
    aen  = (u >= 0 && u < R && (u % P) < T);
    aclr = aen && (u % P) == 0;
    v    = u - 1;
    wen  = (v >= 0 && v < R && (v % P) == T - 1);
    busy = (t >= 1 && t <= 2 + R + L);
    done = (t == TDONE);
    e.flags = {gclr, gen, aclr, aen, wen, busy, done};
    if (wen) begin
      e.addr = 12'(v / P);
      e.addr_chk = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [6:0] s_flags();
    return {s_gen_clr, s_gen_en, s_acc_clr, s_acc_en, s_wr_en, s_busy, s_done};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_small(input string name, input int abort_at,
                           input int spur_a, input int spur_b);
    exp_t e;
    int nd;
    int exp_nd;
    nd = 0;
    repeat ($urandom_range(0, 3)) step();
    s_start = 1'b1;
    s_abort = (abort_at == 0);
    for (int t = 1; t <= TDONE + 3; t++) begin
      step();
      s_start = 1'b0;
      s_abort = 1'b0;
      e = model(t, abort_at);
      checks++;
      if (s_flags() !== e.flags) begin
        errors++;
        $display("FAIL %s t=%0d flags got %b want %b (clr,en,aclr,aen,wr,busy,done)",
                 name, t, s_flags(), e.flags);
      end
      if (e.addr_chk) begin
        checks++;
        if (s_wr_addr !== e.addr) begin
          errors++;
          $display("FAIL %s t=%0d wr_addr got %0d want %0d", name, t, s_wr_addr, e.addr);
        end
      end
      if (s_done === 1'b1) nd++;
      if (t == spur_a || t == spur_b) s_start = 1'b1;
      if (t == abort_at) s_abort = 1'b1;
    end
    s_start = 1'b0;
    s_abort = 1'b0;
    exp_nd = (abort_at < 0 || abort_at >= TDONE) ? 1 : 0;
    checks++;
    if (nd != exp_nd) begin
      errors++;
      $display("FAIL %s done_count got %0d want %0d", name, nd, exp_nd);
    end
  endtask

  task automatic test_reset();
    repeat (3) step();
    checks++;
    if (s_flags() !== 7'b0 || s_wr_addr !== 12'd0) begin
      errors++;
      $display("FAIL reset small got %b/%0d want 0", s_flags(), s_wr_addr);
    end
    checks++;
    if ({d_gen_clr, d_gen_en, d_acc_clr, d_acc_en, d_wr_en, d_busy, d_done} !== 7'b0 ||
        d_wr_addr !== 12'd0) begin
      errors++;
      $display("FAIL reset default outputs nonzero");
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_nominal();
    run_small("nominal", -1, -1, -1);
  endtask

  task automatic test_abort();
    run_small("abort9", 9, -1, -1);
    run_small("after_abort", -1, -1, -1);
    run_small("start_abort_idle", 0, -1, -1);
    run_small("abort_drain", 19, -1, -1);
  endtask

  task automatic test_ignored_start();
    run_small("spur_5_21", -1, 5, 21);
  endtask

  task automatic test_async_reset();
    s_start = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      step();
      s_start = 1'b0;
    end
    checks++;
    if (s_gen_en !== 1'b1 || s_busy !== 1'b1) begin
      errors++;
      $display("FAIL async_pre got en=%b busy=%b want 1,1", s_gen_en, s_busy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (s_flags() !== 7'b0 || s_wr_addr !== 12'd0) begin
      errors++;
      $display("FAIL async_reset got %b/%0d want 0", s_flags(), s_wr_addr);
    end
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (s_flags() !== 7'b0) begin
        errors++;
        $display("FAIL async_idle cycle %0d got %b want 0", i, s_flags());
      end
    end
    run_small("after_rst", -1, -1, -1);
  endtask

  task automatic test_random();
    int a, sa, sb, hi;
    for (int n = 0; n < 10; n++) begin
      a = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 24));
      if (a == 0) begin
        sa = -1;
        sb = -1;
      end else begin
        hi = (a < 0 || a > 21) ? 21 : a;
        sa = int'($urandom_range(1, hi));
        sb = int'($urandom_range(1, hi));
      end
      run_small($sformatf("rand%0d_a%0d", n, a), a, sa, sb);
    end
  endtask

  task automatic test_default();
    int nwr, ngen, last_addr;
    bit seen;
    nwr = 0;
    ngen = 0;
    last_addr = -1;
    seen = 0;
    d_start = 1'b1;
    step();
    d_start = 1'b0;
    for (int i = 0; i < 30000 && !seen; i++) begin
      if (d_gen_en === 1'b1) ngen++;
      if (d_wr_en === 1'b1) begin
        checks++;
        if (d_wr_addr !== 12'(nwr)) begin
          errors++;
          $display("FAIL dflt_addr write %0d got %0d want %0d", nwr, d_wr_addr, nwr);
        end
        last_addr = int'(d_wr_addr);
        nwr++;
      end
      if (d_done === 1'b1) seen = 1;
      else step();
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL dflt_done timeout got 0 want 1");
    end
    checks++;
    if (nwr != 2809) begin
      errors++;
      $display("FAIL dflt_wr_count got %0d want 2809", nwr);
    end
    checks++;
    if (last_addr != 2808) begin
      errors++;
      $display("FAIL dflt_last_addr got %0d want 2808", last_addr);
    end
    checks++;
    if (ngen != 22472) begin
      errors++;
      $display("FAIL dflt_run_cycles got %0d want 22472", ngen);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_abort();
    test_ignored_start();
    test_async_reset();
    test_random();
    test_default();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
